inv_search_bvmul: RTL and testbench
===================================

Name: inv_search_bvmul

Overview:
- Parametrised, sequential successor to the fixed-width combinational invertibility Skolem blocks.
- Given s, t and a comparison op, finds the smallest x in [0, 2^W-1] such that pred((x*s) mod 2^W, t) holds, or reports that no such x exists.
- Sits behind the solver front-end on a valid/ready request/response pair.
- Replaces per-width ABC netlists with one W-generic iterative search that needs no multiplier: the product is accumulated incrementally.

Parameters:
- W, 4, operand/result bit width (legal range 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_s  in  W  multiplier operand s.
- req_t  in  W  comparison bound t.
- req_op  in  2  predicate: 00 UGT (p>t), 01 ULT (p<t), 10 EQ (p==t), 11 UGE (p>=t); p = x*s mod 2^W, all unsigned.
- abort  in  1  cancel the current request, no response.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_x  out  W  smallest satisfying x; 0 when not found.
- resp_found  out  1  1 = solution exists, 0 = exhaustive search failed.
- resp_iters  out  W+1  number of candidates evaluated (1..2^W).

Behaviour:
- Reset: asynchronous on rst_n low.
  - State=IDLE.
  - req_ready=1, resp_valid=0, resp_x=0, resp_found=0, resp_iters=0.
  - Internal x, prod, s, t, op cleared.
  - Reset mid-search or mid-response discards everything; no response is produced.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at an edge: latch s, t, op; x=0; prod=0; iters=0; go to SEARCH.
- SEARCH (one candidate per cycle; req_ready=0):
  - Evaluate pred(prod, t) for the current x and increment iters.
  - If pred is true: resp_x=x, resp_found=1, go to DONE.
  - Else if x==2^W-1: resp_x=0, resp_found=0, go to DONE.
  - Else: x=x+1 and prod=(prod+s) mod 2^W. Wrap-around of prod is intended; there is no saturation.
- Latency:
  - Satisfying x=k: resp_valid rises k+1 clock edges after the accepting edge.
  - No solution: resp_valid rises 2^W edges after the accepting edge.
- DONE:
  - resp_valid=1. resp_x, resp_found and resp_iters are held stable while resp_ready=0.
  - On resp_valid&resp_ready: resp_valid=0, go to IDLE. req_ready rises the cycle after the handshake; there is no same-cycle re-accept.
  - Response fields keep their last values after the handshake until the next result is written.
- abort:
  - Sampled in SEARCH and DONE; forces IDLE at the next edge; resp_valid=0; no response issued.
  - Ignored in IDLE.
  - abort together with a resp handshake in the same cycle: abort wins (treated as a dropped response).
- Inputs req_s, req_t, req_op are sampled only at the accept edge; later changes have no effect.
- Correctness invariants:
  - resp_found=1 implies pred((resp_x*s) mod 2^W, t) holds and no x'<resp_x satisfies pred.
  - resp_found=0 implies no x in [0, 2^W-1] satisfies pred.
  - For W=4, op=UGT, the solvability result must agree with the existing 4-bit bvugt/bvmul Skolem function.
- Boundary conditions:
  - UGT with t=2^W-1 is never satisfiable.
  - ULT with t=0 is never satisfiable.
  - UGE with t=0 is always satisfied at x=0 (resp_iters=1).
  - s=0 gives prod=0 for all x, so the result is decided by pred(0, t), but the search still runs the full 2^W candidates when pred(0, t) is false.

Test Plan:
- W=4, UGT, s=3, t=5 -> resp_x=2, found=1, iters=3, resp_valid 3 edges after accept.
- W=4, EQ, s=6, t=4 -> resp_x=6 (36 mod 16=4), found=1, iters=7. EQ, s=2, t=3 -> found=0, resp_x=0, iters=16, latency 16.
- W=4, UGT, t=15, s=7 -> found=0, iters=16. ULT, t=0 -> found=0. UGE, t=0, any s -> resp_x=0, found=1, iters=1, latency 1.
- Backpressure: UGT, s=1, t=0 -> resp_x=1. Hold resp_ready=0 for 5 cycles: resp_valid, resp_x and resp_found are stable, and req_valid is ignored (req_ready=0). After the handshake, req_ready=1 on the next cycle.
- abort asserted on the 4th SEARCH cycle of EQ, s=2, t=3 -> IDLE next edge, no resp_valid pulse. Then rst_n pulsed low mid-search of a new request -> all outputs return to reset values immediately (asynchronously).
- Exhaustive randomized check at W=4 (all s, t, op) and random sampling at W=8 against a reference model of the invariants, with random resp_ready stalls.

Source files
------------

// File: rtl/inv_search_bvmul_if.sv
// rtl/inv_search_bvmul_if.sv - request/response bundle for the multiplicative inverse search
// The requester drives the master side; the search engine sits on the slave side.
interface inv_search_bvmul_if #(
  parameter int W = 4
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_s;
  logic [W-1:0] req_t;
  logic [1:0]   req_op;
  logic         abort;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_x;
  logic         resp_found;
  logic [W:0]   resp_iters;

  modport master (
    output req_valid, req_s, req_t, req_op, abort, resp_ready,
    input  req_ready, resp_valid, resp_x, resp_found, resp_iters
  );

  modport slave (
    input  req_valid, req_s, req_t, req_op, abort, resp_ready,
    output req_ready, resp_valid, resp_x, resp_found, resp_iters
  );
endinterface

// File: rtl/inv_search_bvmul.sv
// rtl/inv_search_bvmul.sv - smallest x with pred((x*s) mod 2^W, t), one candidate per cycle
// The product is accumulated (prod += s) instead of multiplied, so no multiplier is needed.
module inv_search_bvmul #(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  inv_search_bvmul_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0]   OP_UGT = 2'b00;
  localparam logic [1:0]   OP_ULT = 2'b01;
  localparam logic [1:0]   OP_EQ  = 2'b10;
  localparam logic [W-1:0] X_MAX  = '1;
  localparam logic [W-1:0] X_ONE  = W'(1);
  localparam logic [W:0]   IT_ONE = (W + 1)'(1);

  state_t       state;
  logic [W-1:0] x_q;
  logic [W-1:0] prod_q;
  logic [W-1:0] s_q;
  logic [W-1:0] t_q;
  logic [1:0]   op_q;
  logic         hit;

  logic         req_ready_q;
  logic         resp_valid_q;
  logic [W-1:0] resp_x_q;
  logic         resp_found_q;
  logic [W:0]   resp_iters_q;

  always_comb begin
    hit = 1'b0;
    case (op_q)
      OP_UGT:  hit = (prod_q >  t_q);
      OP_ULT:  hit = (prod_q <  t_q);
      OP_EQ:   hit = (prod_q == t_q);
      default: hit = (prod_q >= t_q);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_q          <= '0;
      prod_q       <= '0;
      s_q          <= '0;
      t_q          <= '0;
      op_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_x_q     <= '0;
      resp_found_q <= 1'b0;
      resp_iters_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            s_q         <= bus.req_s;
            t_q         <= bus.req_t;
            op_q        <= bus.req_op;
            x_q         <= '0;
            prod_q      <= '0;
            req_ready_q <= 1'b0;
            state       <= SEARCH;
          end
        end

        SEARCH: begin
          if (bus.abort) begin
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end else if (hit) begin
            resp_x_q     <= x_q;
            resp_found_q <= 1'b1;
            resp_iters_q <= {1'b0, x_q} + IT_ONE;
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end else if (x_q == X_MAX) begin
            // Exhausted: x_q+1 is exactly 2^W candidates.
            resp_x_q     <= '0;
            resp_found_q <= 1'b0;
            resp_iters_q <= {1'b0, x_q} + IT_ONE;
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end else begin
            x_q    <= x_q + X_ONE;
            prod_q <= prod_q + s_q;
          end
        end

        DONE: begin
          // An abort coinciding with the handshake is just a dropped response.
          if (bus.abort || bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_x     = resp_x_q;
  assign bus.resp_found = resp_found_q;
  assign bus.resp_iters = resp_iters_q;

endmodule

// File: tb/tb_inv_search_bvmul.sv
// tb/tb_inv_search_bvmul.sv - directed and exhaustive checks of inv_search_bvmul at W=4 and W=8
module tb_inv_search_bvmul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_search_bvmul_if #(.W(4)) b4 ();
  inv_search_bvmul_if #(.W(8)) b8 ();

  inv_search_bvmul #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  inv_search_bvmul #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] s;
    logic [3:0] t;
    logic [1:0] op;
    logic [3:0] x;
    logic       f;
    logic [4:0] it;
    int         lat;
  } vec_t;

  // Reference: direct multiplication, independent of the accumulating hardware.
  function automatic void ref_search(input int w, input int s, input int t, input int op,
                                     output int x, output int f, output int it);
    int m;
    int p;
    logic h;
    m = 1 << w;
    x = 0; f = 0; it = m;
    for (int xx = 0; xx < m; xx++) begin
      p = (xx * s) % m;
      case (op)
        0: h = (p > t);
        1: h = (p < t);
        2: h = (p == t);
        default: h = (p >= t);
      endcase
      if (h) begin
        x = xx; f = 1; it = xx + 1;
        return;
      end
    end
  endfunction

  task automatic run4(input logic [3:0] s, input logic [3:0] t, input logic [1:0] op,
                      input int stall, output logic [3:0] rx, output logic rf,
                      output logic [4:0] ri, output int lat);
    @(posedge clk); #1;
    n_checks++;
    if (b4.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run4_req_ready got %b want 1", b4.req_ready);
    end
    b4.req_valid = 1'b1; b4.req_s = s; b4.req_t = t; b4.req_op = op;
    @(posedge clk); #1;
    b4.req_valid = 1'b0; b4.req_s = ~s; b4.req_t = ~t; b4.req_op = ~op;
    lat = 0;
    while (b4.resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (b4.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL run4_timeout s=%0d t=%0d op=%0d resp_valid %b after %0d edges", s, t, op, b4.resp_valid, lat);
    end
    rx = b4.resp_x; rf = b4.resp_found; ri = b4.resp_iters;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({b4.resp_valid, b4.resp_x, b4.resp_found, b4.resp_iters} !== {1'b1, rx, rf, ri}) begin
        n_fail++;
        $display("FAIL run4_stall_hold got v=%b x=%0d f=%b it=%0d want v=1 x=%0d f=%b it=%0d",
                 b4.resp_valid, b4.resp_x, b4.resp_found, b4.resp_iters, rx, rf, ri);
      end
    end
    b4.resp_ready = 1'b1;
    @(posedge clk); #1;
    b4.resp_ready = 1'b0;
    n_checks++;
    if ({b4.resp_valid, b4.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL run4_after_handshake got resp_valid=%b req_ready=%b want 0/1", b4.resp_valid, b4.req_ready);
    end
  endtask

  task automatic run8(input logic [7:0] s, input logic [7:0] t, input logic [1:0] op,
                      input int stall, output logic [7:0] rx, output logic rf,
                      output logic [8:0] ri, output int lat);
    @(posedge clk); #1;
    b8.req_valid = 1'b1; b8.req_s = s; b8.req_t = t; b8.req_op = op;
    @(posedge clk); #1;
    b8.req_valid = 1'b0; b8.req_s = ~s;
    lat = 0;
    while (b8.resp_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (b8.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL run8_timeout s=%0d t=%0d op=%0d", s, t, op);
    end
    rx = b8.resp_x; rf = b8.resp_found; ri = b8.resp_iters;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    b8.resp_ready = 1'b1;
    @(posedge clk); #1;
    b8.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({b4.req_ready, b4.resp_valid, b4.resp_x, b4.resp_found, b4.resp_iters} !== {1'b1, 1'b0, 4'd0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs got rr=%b rv=%b x=%0d f=%b it=%0d want 1 0 0 0 0",
               b4.req_ready, b4.resp_valid, b4.resp_x, b4.resp_found, b4.resp_iters);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({b4.req_ready, b4.resp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release got rr=%b rv=%b want 1 0", b4.req_ready, b4.resp_valid);
    end
  endtask

  task automatic test_directed();
    vec_t v[11];
    logic [3:0] rx;
    logic rf;
    logic [4:0] ri;
    int lat;
    v[0]  = '{s:4'd3,  t:4'd5,  op:2'b00, x:4'd2, f:1'b1, it:5'd3,  lat:3};
    v[1]  = '{s:4'd6,  t:4'd4,  op:2'b10, x:4'd6, f:1'b1, it:5'd7,  lat:7};
    v[2]  = '{s:4'd2,  t:4'd3,  op:2'b10, x:4'd0, f:1'b0, it:5'd16, lat:16};
    v[3]  = '{s:4'd7,  t:4'd15, op:2'b00, x:4'd0, f:1'b0, it:5'd16, lat:16};
    v[4]  = '{s:4'd5,  t:4'd0,  op:2'b01, x:4'd0, f:1'b0, it:5'd16, lat:16};
    v[5]  = '{s:4'd9,  t:4'd0,  op:2'b11, x:4'd0, f:1'b1, it:5'd1,  lat:1};
    v[6]  = '{s:4'd0,  t:4'd0,  op:2'b10, x:4'd0, f:1'b1, it:5'd1,  lat:1};
    v[7]  = '{s:4'd0,  t:4'd3,  op:2'b00, x:4'd0, f:1'b0, it:5'd16, lat:16};
    v[8]  = '{s:4'd4,  t:4'd3,  op:2'b01, x:4'd0, f:1'b1, it:5'd1,  lat:1};
    v[9]  = '{s:4'd5,  t:4'd12, op:2'b11, x:4'd3, f:1'b1, it:5'd4,  lat:4};
    v[10] = '{s:4'd15, t:4'd14, op:2'b00, x:4'd1, f:1'b1, it:5'd2,  lat:2};
    for (int i = 0; i < 11; i++) begin
      run4(v[i].s, v[i].t, v[i].op, i % 3, rx, rf, ri, lat);
      n_checks++;
      if (rx !== v[i].x || rf !== v[i].f || ri !== v[i].it || lat != v[i].lat) begin
        n_fail++;
        $display("FAIL directed_%0d got x=%0d f=%b it=%0d lat=%0d want x=%0d f=%b it=%0d lat=%0d",
                 i, rx, rf, ri, lat, v[i].x, v[i].f, v[i].it, v[i].lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(posedge clk); #1;
    b4.req_valid = 1'b1; b4.req_s = 4'd1; b4.req_t = 4'd0; b4.req_op = 2'b00;
    @(posedge clk); #1;
    b4.req_s = 4'd0; b4.req_t = 4'd9; b4.req_op = 2'b10;
    lat = 0;
    while (b4.resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != 2 || b4.resp_x !== 4'd1 || b4.resp_found !== 1'b1 || b4.resp_iters !== 5'd2) begin
      n_fail++;
      $display("FAIL bp_result got lat=%0d x=%0d f=%b it=%0d want 2 1 1 2", lat, b4.resp_x, b4.resp_found, b4.resp_iters);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({b4.resp_valid, b4.req_ready, b4.resp_x, b4.resp_found, b4.resp_iters} !== {1'b1, 1'b0, 4'd1, 1'b1, 5'd2}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got v=%b rr=%b x=%0d f=%b it=%0d want 1 0 1 1 2",
                 i, b4.resp_valid, b4.req_ready, b4.resp_x, b4.resp_found, b4.resp_iters);
      end
    end
    b4.req_valid = 1'b0;
    b4.resp_ready = 1'b1;
    @(posedge clk); #1;
    b4.resp_ready = 1'b0;
    n_checks++;
    if ({b4.resp_valid, b4.req_ready, b4.resp_x, b4.resp_found} !== {1'b0, 1'b1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_release got v=%b rr=%b x=%0d f=%b want 0 1 1 1", b4.resp_valid, b4.req_ready, b4.resp_x, b4.resp_found);
    end
    @(posedge clk); #1;
    n_checks++;
    if (b4.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_no_stale_accept got req_ready=%b want 1", b4.req_ready);
    end
  endtask

  task automatic test_abort_and_reset();
    int seen;
    @(posedge clk); #1;
    b4.req_valid = 1'b1; b4.req_s = 4'd2; b4.req_t = 4'd3; b4.req_op = 2'b10;
    @(posedge clk); #1;
    b4.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    b4.abort = 1'b1;
    @(posedge clk); #1;
    b4.abort = 1'b0;
    n_checks++;
    if ({b4.req_ready, b4.resp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_idle got rr=%b rv=%b want 1 0", b4.req_ready, b4.resp_valid);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b4.resp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_resp got %0d resp_valid cycles want 0", seen);
    end
    // New request, then asynchronous reset in the middle of its search.
    b4.req_valid = 1'b1; b4.req_s = 4'd2; b4.req_t = 4'd3; b4.req_op = 2'b10;
    @(posedge clk); #1;
    b4.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b4.req_ready, b4.resp_valid, b4.resp_x, b4.resp_found, b4.resp_iters} !== {1'b1, 1'b0, 4'd0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL async_reset got rr=%b rv=%b x=%0d f=%b it=%0d want 1 0 0 0 0",
               b4.req_ready, b4.resp_valid, b4.resp_x, b4.resp_found, b4.resp_iters);
    end
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b4.resp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || b4.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard got %0d resp cycles rr=%b want 0 1", seen, b4.req_ready);
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [3:0] rx;
    logic rf;
    logic [4:0] ri;
    int lat, ex, ef, ei;
    for (int s = 0; s < 16; s++) begin
      for (int t = 0; t < 16; t++) begin
        for (int op = 0; op < 4; op++) begin
          ref_search(4, s, t, op, ex, ef, ei);
          run4(4'(s), 4'(t), 2'(op), int'($urandom_range(0, 2)), rx, rf, ri, lat);
          n_checks++;
          if (rx !== 4'(ex) || rf !== ef[0] || ri !== 5'(ei) || lat != ei) begin
            n_fail++;
            $display("FAIL exh_w4 s=%0d t=%0d op=%0d got x=%0d f=%b it=%0d lat=%0d want x=%0d f=%0d it=%0d lat=%0d",
                     s, t, op, rx, rf, ri, lat, ex, ef, ei, ei);
          end
        end
      end
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] rx;
    logic rf;
    logic [8:0] ri;
    int lat, ex, ef, ei, s, t, op;
    for (int n = 0; n < 40; n++) begin
      s = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 3));
      if (n == 0) begin s = 3; t = 255; op = 0; end
      ref_search(8, s, t, op, ex, ef, ei);
      run8(8'(s), 8'(t), 2'(op), int'($urandom_range(0, 3)), rx, rf, ri, lat);
      n_checks++;
      if (rx !== 8'(ex) || rf !== ef[0] || ri !== 9'(ei) || lat != ei) begin
        n_fail++;
        $display("FAIL rnd_w8 s=%0d t=%0d op=%0d got x=%0d f=%b it=%0d lat=%0d want x=%0d f=%0d it=%0d lat=%0d",
                 s, t, op, rx, rf, ri, lat, ex, ef, ei, ei);
      end
    end
  endtask

  initial begin
    b4.req_valid = 1'b0; b4.req_s = '0; b4.req_t = '0; b4.req_op = '0; b4.abort = 1'b0; b4.resp_ready = 1'b0;
    b8.req_valid = 1'b0; b8.req_s = '0; b8.req_t = '0; b8.req_op = '0; b8.abort = 1'b0; b8.resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort_and_reset();
    test_exhaustive_w4();
    test_random_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
